demux7_collector: RTL and testbench
===================================

// Module: demux7_collector
// PURPOSE
//  Inverse of the lab 7:1 select mux. Routes a 1-bit input stream into 7 output lanes
//  and hands the assembled word downstream with a valid/ready handshake.
//  Lanes are chosen either by an external 3-bit select (addressed mode)
//  or by an internal wrapping pointer (sequential mode).
//  Sits between SW-driven bit entry and the LEDR/consumer side of the lab top level.
// PARAMETERS
//  LANES  7  number of output lanes, legal range 2..8
//  SELW   3  width of sel and ptr; must satisfy 2**SELW >= LANES
// PORTS
//  clock      in   1      rising-edge clock, sole clock domain
//  resetn     in   1      asynchronous, active-low reset
//  clear      in   1      synchronous clear; priority over all other inputs
//  mode       in   1      0 = addressed (lane = sel), 1 = sequential (lane = ptr)
//  sel        in   SELW   lane select used in addressed mode
//  in_valid   in   1      in_bit is valid this cycle
//  in_bit     in   1      data bit
//  in_ready   out  1      collector accepts a bit this cycle
//  out_word   out  LANES  assembled word; bit i = lane i
//  out_valid  out  1      out_word complete and held for the consumer
//  out_ready  in   1      consumer takes out_word
//  ptr        out  SELW   sequential-mode lane pointer
//  sel_err    out  1      sticky: an addressed write used sel >= LANES
// BEHAVIOUR
//  Reset (resetn low, async):
//   - out_word = 0, out_valid = 0, ptr = 0, sel_err = 0.
//   - Internal written-mask = 0, state = FILL.
//   - in_ready is forced 0 while resetn is low.
//  States:
//   - FILL: in_ready = 1, out_valid = 0.
//   - FULL: in_ready = 0, out_valid = 1, out_word frozen.
//  Accept: a bit is accepted when in_valid && in_ready. mode and sel are sampled on that cycle.
//  Lane for an accepted bit:
//   - Sequential mode: lane = ptr.
//   - Addressed mode: lane = sel. If sel >= LANES, lane = LANES-1 and sel_err is set
//     (mirrors the mux default).
//  On accept:
//   - out_word[lane] <= in_bit and mask[lane] <= 1.
//   - Sequential mode only: ptr <= (ptr == LANES-1) ? 0 : ptr+1. Addressed mode leaves ptr unchanged.
//  Duplicate addressed write to a lane: overwrites the data bit; the mask is unaffected.
//  FILL -> FULL on the edge where the accept makes mask all-ones.
//   - out_valid rises the cycle after the final accepted bit (latency 1).
//  FULL -> FILL on the edge where out_ready = 1.
//   - mask <= 0 and ptr <= 0. out_word keeps its value; out_valid falls next cycle.
//   - No bit is accepted in the handoff cycle (no bypass).
//  out_ready while in FILL: ignored.
//  in_valid while in FULL: ignored; the bit is not consumed, and the source holds it.
//  Mode switches mid-word are legal. The mask decides completion regardless of which mode wrote each lane.
//  clear = 1 (synchronous):
//   - mask = 0, ptr = 0, out_word = 0, out_valid = 0, sel_err = 0, state = FILL.
//   - Any simultaneous accept or handoff is discarded.
//  Reset mid-word or mid-handoff: everything returns to reset values immediately. The partial word is lost.
//  sel_err changes only on clear or reset.
// TESTING
//  1. Sequential: 7 accepts of 1,0,1,1,0,0,1 with out_ready = 0
//     -> out_word = 7'b1001101 and out_valid = 1 one cycle after the 7th bit;
//     in_ready = 0; ptr = 0 after the 7th accept.
//  2. Handoff: after test 1, pulse out_ready
//     -> next cycle out_valid = 0, in_ready = 1, ptr = 0, out_word still 7'b1001101.
//  3. Addressed: sel = 6,5,4,3,2,1,0 with bits 1,1,1,1,1,1,1, then sel = 3 with bit 0 before the 7th
//     -> lane 3 overwritten, no early out_valid; out_valid only after all 7 lanes are written.
//  4. Addressed sel = 7 with bit 1 -> out_word[6] = 1, sel_err = 1 and stays 1 until clear.
//  5. Backpressure: in FULL, hold in_valid = 1 for 5 cycles
//     -> no accepts, out_word unchanged, ptr unchanged.
//  6. clear asserted on the cycle of the 4th sequential accept -> all outputs 0 next cycle.
//     Separately, resetn low mid-word -> immediate zeros and in_ready = 0.

Source files
------------

// File: rtl/demux7_collector_if.sv
// Handshake bundle between the bit source, the lane collector and the word consumer.
// The master side drives bits and takes words; the slave side is the collector itself.
interface demux7_collector_if #(
    parameter int LANES = 7,
    parameter int SELW  = 3
);
    logic              clear;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic [LANES-1:0]  out_word;
    logic              out_valid;
    logic              out_ready;
    logic [SELW-1:0]   ptr;
    logic              sel_err;

    modport master (
        output clear, mode, sel, in_valid, in_bit, out_ready,
        input  in_ready, out_word, out_valid, ptr, sel_err
    );

    modport slave (
        input  clear, mode, sel, in_valid, in_bit, out_ready,
        output in_ready, out_word, out_valid, ptr, sel_err
    );
endinterface

// File: rtl/demux7_collector.sv
// Serial-to-lane collector: steers single bits into LANES lanes (addressed or
// sequential) and presents the completed word with a valid/ready handshake.
module demux7_collector #(
    parameter int LANES = 7,
    parameter int SELW  = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    demux7_collector_if.slave     bus
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [SELW:0]     LANES_W   = LANES[SELW:0];
    localparam logic [SELW-1:0]   LAST_LANE = SELW'(LANES - 1);
    localparam logic [SELW-1:0]   PTR_ONE   = SELW'(1'b1);
    localparam logic [LANES-1:0]  ALL_ONES  = {LANES{1'b1}};
    localparam logic [LANES-1:0]  NO_LANES  = {LANES{1'b0}};

    state_t             state_r;
    logic [LANES-1:0]   word_r;
    logic [LANES-1:0]   mask_r;
    logic [SELW-1:0]    ptr_r;
    logic               valid_r;
    logic               sel_err_r;

    logic [SELW-1:0]    lane_s;
    logic [LANES-1:0]   lane_oh_s;
    logic               sel_oor_s;
    logic               accept_s;
    logic               in_ready_s;

    function automatic logic [LANES-1:0] lane_onehot(input logic [SELW-1:0] lane);
        lane_onehot = {{(LANES-1){1'b0}}, 1'b1} << lane;
    endfunction

    // Ready follows the state but is held low while reset is asserted, without waiting for a clock.
    assign in_ready_s = resetn && (state_r == FILL);

    // Lane decode for the current cycle; an out-of-range select falls to the last lane like the mux default.
    always_comb begin
        lane_s    = ptr_r;
        sel_oor_s = 1'b0;
        if (bus.mode) begin
            lane_s    = ptr_r;
            sel_oor_s = 1'b0;
        end else if ({1'b0, bus.sel} >= LANES_W) begin
            lane_s    = LAST_LANE;
            sel_oor_s = 1'b1;
        end else begin
            lane_s    = bus.sel;
            sel_oor_s = 1'b0;
        end
        lane_oh_s = lane_onehot(lane_s);
        accept_s  = bus.in_valid && in_ready_s;
    end

    // Collector state machine: fill lanes until the mask is complete, then hold until the consumer takes the word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= FILL;
            word_r    <= NO_LANES;
            mask_r    <= NO_LANES;
            ptr_r     <= {SELW{1'b0}};
            valid_r   <= 1'b0;
            sel_err_r <= 1'b0;
        end else if (bus.clear) begin
            state_r   <= FILL;
            word_r    <= NO_LANES;
            mask_r    <= NO_LANES;
            ptr_r     <= {SELW{1'b0}};
            valid_r   <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        word_r <= (word_r & ~lane_oh_s) | (bus.in_bit ? lane_oh_s : NO_LANES);
                        mask_r <= mask_r | lane_oh_s;
                        if (bus.mode) begin
                            ptr_r <= (ptr_r == LAST_LANE) ? {SELW{1'b0}} : ptr_r + PTR_ONE;
                        end else begin
                            ptr_r <= ptr_r;
                        end
                        if (sel_oor_s) begin
                            sel_err_r <= 1'b1;
                        end else begin
                            sel_err_r <= sel_err_r;
                        end
                        if ((mask_r | lane_oh_s) == ALL_ONES) begin
                            state_r <= FULL;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= FILL;
                            valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= FILL;
                        valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    // Handoff cycle never accepts a bit; the word itself stays visible after release.
                    if (bus.out_ready) begin
                        state_r <= FILL;
                        valid_r <= 1'b0;
                        mask_r  <= NO_LANES;
                        ptr_r   <= {SELW{1'b0}};
                    end else begin
                        state_r <= FULL;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= FILL;
                    valid_r <= 1'b0;
                    mask_r  <= NO_LANES;
                    ptr_r   <= {SELW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_word  = word_r;
    assign bus.out_valid = valid_r;
    assign bus.ptr       = ptr_r;
    assign bus.sel_err   = sel_err_r;

endmodule

// File: tb/tb_demux7_collector.sv
// Randomized and directed bench for demux7_collector against a lane-array reference model.
module tb_demux7_collector;

    localparam int LANES = 7;
    localparam int SELW  = 3;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    demux7_collector_if #(.LANES(LANES), .SELW(SELW)) bus ();

    demux7_collector #(.LANES(LANES), .SELW(SELW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int check_cnt = 0;
    int error_cnt = 0;

    // Reference model: one entry per lane, plus pointer, full flag and sticky error.
    bit m_word [LANES];
    bit m_mask [LANES];
    int m_ptr;
    bit m_full;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_word[i] = 1'b0;
            m_mask[i] = 1'b0;
        end
        m_ptr  = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < LANES; i++) v[i] = m_word[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int lane;
        int written;
        if (bus.clear) begin
            model_reset();
        end else if (!m_full) begin
            if (bus.in_valid) begin
                if (bus.mode) begin
                    lane = m_ptr;
                end else if (int'(bus.sel) < LANES) begin
                    lane = int'(bus.sel);
                end else begin
                    lane  = LANES - 1;
                    m_err = 1'b1;
                end
                m_word[lane] = bus.in_bit;
                m_mask[lane] = 1'b1;
                if (bus.mode) m_ptr = (m_ptr + 1) % LANES;
                written = 0;
                for (int i = 0; i < LANES; i++) written += int'(m_mask[i]);
                if (written == LANES) m_full = 1'b1;
            end
        end else if (bus.out_ready) begin
            m_full = 1'b0;
            m_ptr  = 0;
            for (int i = 0; i < LANES; i++) m_mask[i] = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_word"},  32'(bus.out_word),  model_word());
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_full));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(!m_full));
        check({tag, ".ptr"},       32'(bus.ptr),       32'(m_ptr));
        check({tag, ".sel_err"},   32'(bus.sel_err),   32'(m_err));
    endtask

    task automatic drive(input logic clr, input logic md, input logic [SELW-1:0] s,
                         input logic iv, input logic ib, input logic ordy);
        bus.clear     = clr;
        bus.mode      = md;
        bus.sel       = s;
        bus.in_valid  = iv;
        bus.in_bit    = ib;
        bus.out_ready = ordy;
    endtask

    task automatic step(input string tag);
        model_clock();
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    logic [LANES-1:0] held_word;
    logic [SELW-1:0]  held_ptr;
    bit seq_bits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int addr_sel [6] = '{6, 5, 4, 3, 2, 1};

    initial begin
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.out_word", 32'(bus.out_word), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        compare_all("rst");

        // Test 1: sequential fill
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, seq_bits[i], 1'b0);
            step("seq");
        end
        drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        check("t1.word",  32'(bus.out_word),  32'(7'b1001101));
        check("t1.valid", 32'(bus.out_valid), 32'd1);
        check("t1.ready", 32'(bus.in_ready),  32'd0);
        check("t1.ptr",   32'(bus.ptr),       32'd0);

        // Test 2: handoff
        drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        step("handoff");
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("t2.valid", 32'(bus.out_valid), 32'd0);
        check("t2.ready", 32'(bus.in_ready),  32'd1);
        check("t2.word",  32'(bus.out_word),  32'(7'b1001101));

        // Test 3: addressed fill with a duplicate write to lane 3
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, SELW'(addr_sel[i]), 1'b1, 1'b1, 1'b0);
            step("addr");
        end
        drive(1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        step("addr.dup");
        check("t3.no_early_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step("addr.last");
        check("t3.word",  32'(bus.out_word),  32'(7'b1110111));
        check("t3.valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("t3.handoff");

        // Test 4: out-of-range select lands on the last lane and latches the error
        drive(1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
        step("oor");
        check("t4.lane6",   32'(bus.out_word[6]), 32'd1);
        check("t4.sel_err", 32'(bus.sel_err),     32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, 1'($urandom_range(1)), 1'b0);
            step("t4.seq");
        end
        check("t4.full", 32'(bus.out_valid), 32'd1);

        // Test 5: backpressure while full
        held_word = bus.out_word;
        held_ptr  = bus.ptr;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'($urandom_range(1)), SELW'($urandom_range(7)), 1'b1, 1'($urandom_range(1)), 1'b0);
            step("bp");
        end
        check("t5.word", 32'(bus.out_word), 32'(held_word));
        check("t5.ptr",  32'(bus.ptr),      32'(held_ptr));
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("t5.handoff");
        check("t5.err_sticky", 32'(bus.sel_err), 32'd1);

        // Test 6: clear on the 4th sequential accept, then async reset mid-word
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
            step("t6.seq");
        end
        drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        step("t6.clear");
        check("t6.word",    32'(bus.out_word), 32'd0);
        check("t6.ptr",     32'(bus.ptr),      32'd0);
        check("t6.sel_err", 32'(bus.sel_err),  32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
            step("t6.pre_rst");
        end
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("t6.rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("t6.rst.word",     32'(bus.out_word), 32'd0);
        check("t6.rst.ptr",      32'(bus.ptr),      32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        compare_all("t6.rst");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(39) == 0), 1'($urandom_range(1)), SELW'($urandom_range(7)),
                  1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(2) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
